// File: rtl/psr_cond_unit_if.sv
// ============================================================================
//  Module      : psr_cond_unit_if
//  Description : Flag-update, PSR access and condition-evaluation signals
//                between the decode/ALU side and the PSR condition unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface psr_cond_unit_if #(
  parameter int WIDTH = 16
);
  // ALU flag update path, field order {C,F,Z,L,N}
  logic             flags_en;
  logic [4:0]       flags_sel;
  logic [4:0]       flags_raw;
  logic             psr_c_out;
  logic [4:0]       psr_flags;

  // LPR / SPR word access and interrupt shadow control
  logic             psr_we;
  logic [WIDTH-1:0] psr_wdata;
  logic [WIDTH-1:0] psr_rdata;
  logic             psr_save;
  logic             psr_restore;

  // Condition request / result handshakes
  logic             cond_valid;
  logic             cond_ready;
  logic [3:0]       cond_code;
  logic             take_valid;
  logic             take_ready;
  logic             take;

  // Decoder / ALU side
  modport master (
    output flags_en, flags_sel, flags_raw,
    output psr_we, psr_wdata, psr_save, psr_restore,
    output cond_valid, cond_code, take_ready,
    input  psr_c_out, psr_flags, psr_rdata,
    input  cond_ready, take_valid, take
  );

  // PSR condition unit side
  modport slave (
    input  flags_en, flags_sel, flags_raw,
    input  psr_we, psr_wdata, psr_save, psr_restore,
    input  cond_valid, cond_code, take_ready,
    output psr_c_out, psr_flags, psr_rdata,
    output cond_ready, take_valid, take
  );
endinterface

`default_nettype wire

// File: rtl/psr_cond_unit.sv
// ============================================================================
//  Module      : psr_cond_unit
//  Description : Processor status register {C,F,Z,L,N} with masked ALU flag
//                merge, LPR/SPR word access, interrupt shadow, and a one-entry
//                valid/ready condition-code evaluation pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module psr_cond_unit #(
  parameter int WIDTH     = 16,
  parameter bit SHADOW_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  psr_cond_unit_if.slave      bus
);

  // Flag positions inside the 5-bit PSR vector {C,F,Z,L,N}
  localparam int c_FLAG_C = 4;
  localparam int c_FLAG_F = 3;
  localparam int c_FLAG_Z = 2;
  localparam int c_FLAG_L = 1;
  localparam int c_FLAG_N = 0;

  // Flag positions inside the packed LPR/SPR word
  localparam int c_WORD_C = 0;
  localparam int c_WORD_L = 2;
  localparam int c_WORD_F = 5;
  localparam int c_WORD_Z = 6;
  localparam int c_WORD_N = 7;

  logic [4:0]       r_psr;
  logic [4:0]       w_psr_next;
  logic [4:0]       w_shadow;
  logic             w_restore;
  logic [4:0]       w_wdata_flags;
  logic [WIDTH-1:0] w_rdata;
  logic             w_accept;
  logic             w_cond_base;
  logic             w_cond_true;
  logic             r_take_valid;
  logic             r_take;
  logic             w_unused_wdata;

  // Only five bits of the written word carry flags; the rest are don't-care
  assign w_unused_wdata = ^bus.psr_wdata;

  // Unpack the LPR word into flag order
  assign w_wdata_flags = {bus.psr_wdata[c_WORD_C], bus.psr_wdata[c_WORD_F],
                          bus.psr_wdata[c_WORD_Z], bus.psr_wdata[c_WORD_L],
                          bus.psr_wdata[c_WORD_N]};

  // Shadow register exists only when enabled; otherwise restore is inert so
  // it cannot mask a simultaneous LPR or flag update
  generate
    if (SHADOW_EN) begin : g_shadow
      logic [4:0] r_shadow;

      // Shadow captures the pre-edge PSR, which gives swap on save+restore
      always_ff @(posedge clk) begin
        if (reset) begin
          r_shadow <= '0;
        end else if (bus.psr_save) begin
          r_shadow <= r_psr;
        end
      end

      assign w_shadow  = r_shadow;
      assign w_restore = bus.psr_restore;
    end else begin : g_no_shadow
      logic w_unused_shadow_ctl;

      assign w_unused_shadow_ctl = bus.psr_save ^ bus.psr_restore;
      assign w_shadow            = '0;
      assign w_restore           = 1'b0;
    end
  endgenerate

  // Next PSR: restore beats LPR beats masked ALU merge beats hold
  always_comb begin
    w_psr_next = r_psr;
    if (w_restore) begin
      w_psr_next = w_shadow;
    end else if (bus.psr_we) begin
      w_psr_next = w_wdata_flags;
    end else if (bus.flags_en) begin
      w_psr_next = (r_psr & ~bus.flags_sel) | (bus.flags_raw & bus.flags_sel);
    end
  end

  // PSR state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_psr <= '0;
    end else begin
      r_psr <= w_psr_next;
    end
  end

  // Pack the registered PSR for SPR; unused word bits read as zero
  always_comb begin
    w_rdata           = '0;
    w_rdata[c_WORD_C] = r_psr[c_FLAG_C];
    w_rdata[c_WORD_L] = r_psr[c_FLAG_L];
    w_rdata[c_WORD_F] = r_psr[c_FLAG_F];
    w_rdata[c_WORD_Z] = r_psr[c_FLAG_Z];
    w_rdata[c_WORD_N] = r_psr[c_FLAG_N];
  end

  // Codes come in true/complement pairs: evaluate the even member of the pair
  // from the forwarded PSR and invert for odd codes
  always_comb begin
    w_cond_base = 1'b0;
    case (bus.cond_code[3:1])
      3'd0:    w_cond_base = w_psr_next[c_FLAG_Z];
      3'd1:    w_cond_base = w_psr_next[c_FLAG_C];
      3'd2:    w_cond_base = w_psr_next[c_FLAG_L];
      3'd3:    w_cond_base = w_psr_next[c_FLAG_N];
      3'd4:    w_cond_base = w_psr_next[c_FLAG_F];
      3'd5:    w_cond_base = ~(w_psr_next[c_FLAG_L] | w_psr_next[c_FLAG_Z]);
      3'd6:    w_cond_base = ~(w_psr_next[c_FLAG_N] | w_psr_next[c_FLAG_Z]);
      3'd7:    w_cond_base = 1'b1;
      default: w_cond_base = 1'b0;
    endcase
  end

  assign w_cond_true = w_cond_base ^ bus.cond_code[0];

  // One-entry pipe: accept whenever the slot is empty or draining this cycle
  assign w_accept = bus.cond_valid && (!r_take_valid || bus.take_ready);

  // Result slot: load on accept, clear when consumed with nothing behind it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_take_valid <= 1'b0;
      r_take       <= 1'b0;
    end else if (w_accept) begin
      r_take_valid <= 1'b1;
      r_take       <= w_cond_true;
    end else if (bus.take_ready) begin
      r_take_valid <= 1'b0;
    end
  end

  assign bus.psr_c_out  = r_psr[c_FLAG_C];
  assign bus.psr_flags  = r_psr;
  assign bus.psr_rdata  = w_rdata;
  assign bus.cond_ready = !r_take_valid || bus.take_ready;
  assign bus.take_valid = r_take_valid;
  assign bus.take       = r_take;

endmodule

`default_nettype wire

// File: tb/tb_psr_cond_unit.sv
// ============================================================================
//  Module      : tb_psr_cond_unit
//  Description : Self-checking bench for psr_cond_unit with a behavioural
//                reference model of the PSR, shadow and result slot.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_psr_cond_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  // Reference model state
  logic [4:0] m_psr;
  logic [4:0] m_shadow;
  logic       m_tv;
  logic       m_take;

  psr_cond_unit_if #(.WIDTH(16)) bus ();

  psr_cond_unit #(.WIDTH(16), .SHADOW_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Condition table written directly from named flags
  function automatic logic cond_true(input logic [4:0] f, input logic [3:0] code);
    logic c, fl, z, l, n;
    c = f[4]; fl = f[3]; z = f[2]; l = f[1]; n = f[0];
    case (code)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return l;
      4'h5: return !l;
      4'h6: return n;
      4'h7: return !n;
      4'h8: return fl;
      4'h9: return !fl;
      4'hA: return !l && !z;
      4'hB: return l || z;
      4'hC: return !n && !z;
      4'hD: return n || z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] pack(input logic [4:0] f);
    logic [15:0] w;
    w = 16'h0000;
    w[0] = f[4]; w[5] = f[3]; w[6] = f[2]; w[2] = f[1]; w[7] = f[0];
    return w;
  endfunction

  function automatic logic [4:0] unpack(input logic [15:0] w);
    return {w[0], w[5], w[6], w[2], w[7]};
  endfunction

  task automatic idle_inputs();
    bus.flags_en    = 1'b0;
    bus.flags_sel   = 5'h00;
    bus.flags_raw   = 5'h00;
    bus.psr_we      = 1'b0;
    bus.psr_wdata   = 16'h0000;
    bus.psr_save    = 1'b0;
    bus.psr_restore = 1'b0;
    bus.cond_valid  = 1'b0;
    bus.cond_code   = 4'h0;
    bus.take_ready  = 1'b1;
  endtask

  // Advance one clock, updating the model from the inputs currently driven
  task automatic cycle();
    logic [4:0] np, ns;
    logic       ntv, nt, acc;
    acc = bus.cond_valid && (!m_tv || bus.take_ready);
    np = m_psr; ns = m_shadow; ntv = m_tv; nt = m_take;
    if (reset) begin
      np = 5'h00; ns = 5'h00; ntv = 1'b0; nt = 1'b0;
    end else begin
      if (bus.psr_restore)   np = m_shadow;
      else if (bus.psr_we)   np = unpack(bus.psr_wdata);
      else if (bus.flags_en) np = (m_psr & ~bus.flags_sel) | (bus.flags_raw & bus.flags_sel);
      if (bus.psr_save) ns = m_psr;
      if (acc) begin
        ntv = 1'b1;
        nt  = cond_true(np, bus.cond_code);
      end else if (bus.take_ready) begin
        ntv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_psr = np; m_shadow = ns; m_tv = ntv; m_take = nt;
  endtask

  task automatic set_psr(input logic [4:0] f);
    idle_inputs();
    bus.psr_we    = 1'b1;
    bus.psr_wdata = pack(f);
    cycle();
    idle_inputs();
  endtask

  task automatic test_reset();
    set_psr(5'h1F);
    bus.take_ready = 1'b0;
    bus.cond_valid = 1'b1;
    bus.cond_code  = 4'hE;
    cycle();
    idle_inputs();
    bus.take_ready = 1'b0;
    n_checks++;
    if (bus.psr_flags !== 5'h1F || bus.take_valid !== 1'b1)
      $display("FAIL reset_pre: flags=%h tv=%b required 1f/1", bus.psr_flags, bus.take_valid);
    else n_pass++;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus.take_ready = 1'b1;
    n_checks++;
    if (bus.psr_flags !== 5'h00 || bus.psr_rdata !== 16'h0000 || bus.psr_c_out !== 1'b0)
      $display("FAIL reset_psr: flags=%h rdata=%h c=%b required 0", bus.psr_flags, bus.psr_rdata, bus.psr_c_out);
    else n_pass++;
    n_checks++;
    if (bus.take_valid !== 1'b0 || bus.take !== 1'b0 || bus.cond_ready !== 1'b1)
      $display("FAIL reset_pipe: tv=%b take=%b ready=%b required 0/0/1", bus.take_valid, bus.take, bus.cond_ready);
    else n_pass++;
  endtask

  task automatic test_masked_update();
    set_psr(5'b10101);
    bus.flags_en  = 1'b1;
    bus.flags_sel = 5'b01100;
    bus.flags_raw = 5'b01010;
    cycle();
    idle_inputs();
    n_checks++;
    if (bus.psr_flags !== 5'b11001 || bus.psr_c_out !== 1'b1)
      $display("FAIL masked_update: flags=%b c=%b required 11001/1", bus.psr_flags, bus.psr_c_out);
    else n_pass++;
    bus.flags_en  = 1'b1;
    bus.flags_sel = 5'b00000;
    bus.flags_raw = 5'b00110;
    cycle();
    idle_inputs();
    n_checks++;
    if (bus.psr_flags !== 5'b11001)
      $display("FAIL masked_sel0: flags=%b required 11001", bus.psr_flags);
    else n_pass++;
  endtask

  task automatic test_forwarding();
    for (int k = 0; k < 2; k++) begin
      set_psr(5'h00);
      bus.flags_en   = 1'b1;
      bus.flags_sel  = 5'h1F;
      bus.flags_raw  = 5'b00100;
      bus.cond_valid = 1'b1;
      bus.cond_code  = (k == 0) ? 4'h0 : 4'h1;
      cycle();
      idle_inputs();
      n_checks++;
      if (bus.take_valid !== 1'b1 || bus.take !== (k == 0))
        $display("FAIL forwarding_%0d: tv=%b take=%b required 1/%0d", k, bus.take_valid, bus.take, (k == 0));
      else n_pass++;
    end
    cycle();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    cycle();
    bus.take_ready = 1'b0;
    bus.cond_valid = 1'b1;
    bus.cond_code  = 4'hE;
    cycle();
    bus.cond_code  = 4'hF;
    cycle();
    n_checks++;
    if (bus.take_valid !== 1'b1 || bus.take !== 1'b1 || bus.cond_ready !== 1'b0)
      $display("FAIL bp_hold: tv=%b take=%b ready=%b required 1/1/0", bus.take_valid, bus.take, bus.cond_ready);
    else n_pass++;
    bus.take_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.cond_ready !== 1'b1)
      $display("FAIL bp_release_ready: ready=%b required 1", bus.cond_ready);
    else n_pass++;
    cycle();
    bus.cond_valid = 1'b0;
    n_checks++;
    if (bus.take_valid !== 1'b1 || bus.take !== 1'b0)
      $display("FAIL bp_no_bubble: tv=%b take=%b required 1/0", bus.take_valid, bus.take);
    else n_pass++;
    cycle();
    n_checks++;
    if (bus.take_valid !== 1'b0)
      $display("FAIL bp_drain: tv=%b required 0", bus.take_valid);
    else n_pass++;
  endtask

  task automatic test_priority_shadow();
    set_psr(5'b00011);
    bus.psr_save = 1'b1;
    cycle();
    idle_inputs();
    bus.psr_we    = 1'b1;
    bus.psr_wdata = 16'h0041;
    bus.flags_en  = 1'b1;
    bus.flags_sel = 5'h1F;
    bus.flags_raw = 5'h00;
    cycle();
    idle_inputs();
    n_checks++;
    if (bus.psr_flags !== 5'b10100 || bus.psr_rdata !== 16'h0041)
      $display("FAIL prio_we: flags=%b rdata=%h required 10100/0041", bus.psr_flags, bus.psr_rdata);
    else n_pass++;
    bus.psr_restore = 1'b1;
    bus.psr_we      = 1'b1;
    bus.psr_wdata   = 16'h00FF;
    cycle();
    idle_inputs();
    n_checks++;
    if (bus.psr_flags !== 5'b00011)
      $display("FAIL restore: flags=%b required 00011", bus.psr_flags);
    else n_pass++;
    set_psr(5'b10100);
    bus.psr_save    = 1'b1;
    bus.psr_restore = 1'b1;
    cycle();
    idle_inputs();
    n_checks++;
    if (bus.psr_flags !== 5'b00011)
      $display("FAIL swap_psr: flags=%b required 00011", bus.psr_flags);
    else n_pass++;
    bus.psr_restore = 1'b1;
    cycle();
    idle_inputs();
    n_checks++;
    if (bus.psr_flags !== 5'b10100)
      $display("FAIL swap_shadow: flags=%b required 10100", bus.psr_flags);
    else n_pass++;
  endtask

  task automatic test_exhaustive();
    idle_inputs();
    for (int f = 0; f < 32; f++) begin
      for (int code = 0; code < 16; code++) begin
        bus.flags_en   = 1'b1;
        bus.flags_sel  = 5'h1F;
        bus.flags_raw  = 5'(f);
        bus.cond_valid = 1'b1;
        bus.cond_code  = 4'(code);
        cycle();
        n_checks++;
        if (bus.take_valid !== 1'b1 || bus.take !== cond_true(5'(f), 4'(code)))
          $display("FAIL cond f=%b code=%h: tv=%b take=%b required 1/%b",
                   5'(f), 4'(code), bus.take_valid, bus.take, cond_true(5'(f), 4'(code)));
        else n_pass++;
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset           = ($urandom_range(0, 49) == 0);
      bus.flags_en    = $urandom_range(0, 1);
      bus.flags_sel   = 5'($urandom);
      bus.flags_raw   = 5'($urandom);
      bus.psr_we      = ($urandom_range(0, 5) == 0);
      bus.psr_wdata   = 16'($urandom);
      bus.psr_save    = ($urandom_range(0, 7) == 0);
      bus.psr_restore = ($urandom_range(0, 7) == 0);
      bus.cond_valid  = $urandom_range(0, 1);
      bus.cond_code   = 4'($urandom);
      bus.take_ready  = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (bus.cond_ready !== (!m_tv || bus.take_ready))
        $display("FAIL rnd_ready[%0d]: got %b required %b", i, bus.cond_ready, (!m_tv || bus.take_ready));
      else n_pass++;
      cycle();
      n_checks++;
      if (bus.psr_flags !== m_psr || bus.psr_c_out !== m_psr[4] || bus.psr_rdata !== pack(m_psr))
        $display("FAIL rnd_psr[%0d]: flags=%b c=%b rdata=%h required %b/%b/%h",
                 i, bus.psr_flags, bus.psr_c_out, bus.psr_rdata, m_psr, m_psr[4], pack(m_psr));
      else n_pass++;
      n_checks++;
      if (bus.take_valid !== m_tv || (m_tv && bus.take !== m_take))
        $display("FAIL rnd_take[%0d]: tv=%b take=%b required %b/%b", i, bus.take_valid, bus.take, m_tv, m_take);
      else n_pass++;
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_psr = 5'h00; m_shadow = 5'h00; m_tv = 1'b0; m_take = 1'b0;
    reset = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    reset = 1'b0;
    test_reset();
    test_masked_update();
    test_forwarding();
    test_backpressure();
    test_priority_shadow();
    test_exhaustive();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
